// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FSM state type, status bit indices and bias helper for the FPU add/sub unit
package fpu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} fpu_state_t;
  localparam int ST_EXACT   = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_UNF     = 2;
  localparam int ST_INEXACT = 3;
  function automatic int fpu_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
endpackage

// File: rtl/fpu_align_shift.sv
// fpu_align_shift: combinational right shifter that ORs every shifted-out bit into the LSB (sticky)
//   i_data [WIDTH-1:0]  value to shift
//   i_amt  [SHW-1:0]    shift distance; distances >= WIDTH collapse the result to the sticky bit alone
//   o_data [WIDTH-1:0]  shifted value with sticky in bit 0
module fpu_align_shift #(
  parameter int WIDTH = 29,
  parameter int SHW   = 6
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_amt,
  output logic [WIDTH-1:0] o_data
);
  logic w_stk;
  // an over-range shift yields 0 from >> and an all-ones lost mask, so the collapse needs no special case
  always_comb begin
    w_stk  = |(i_data & ~({WIDTH{1'b1}} << i_amt));
    o_data = (i_data >> i_amt) | {{(WIDTH-1){1'b0}}, w_stk};
  end
endmodule

// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: multi-cycle parametrised floating-point adder/subtractor with start/done handshake
//   clock            rising-edge clock
//   reset            synchronous, active-low
//   start            accept operands while idle
//   op_sub           0: A+B, 1: A-B (B sign inverted at capture)
//   op_A_in/op_B_in  operands {sign, exp, man}
//   busy             high from the cycle after accept until done
//   done             one-cycle result-valid pulse
//   data_out         result, held until next done
//   status_out       {INEXACT, UNDERFLOW, OVERFLOW, EXACT}, held with data_out
// Build option: define FPU_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fpu_addsub_seq
  import fpu_pkg::*;
#(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   op_A_in,
  input  logic [EXP_W+MAN_W:0]   op_B_in,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   data_out,
  output logic [3:0]             status_out
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam int NW = MAN_W + 5;
  localparam logic [EXP_W-1:0] EMAX  = '1;
  localparam logic [EXP_W-1:0] E_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [3:0] K_EXACT = 4'(1 << ST_EXACT);
  localparam logic [3:0] K_INX   = 4'(1 << ST_INEXACT);
  localparam logic [3:0] K_OVF   = 4'((1 << ST_OVF) | (1 << ST_INEXACT));
  localparam logic [3:0] K_UNF   = 4'((1 << ST_UNF) | (1 << ST_INEXACT));
  fpu_state_t r_state;
  logic [W-1:0] r_a, r_b, r_res;
  logic [3:0] r_st;
  logic r_sign, r_ovf, r_unf;
  logic [EXP_W-1:0] r_exp;
  logic [SW-1:0] r_sml;
  logic [NW-1:0] r_sum;
  logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_spec, w_swap, w_eff_sub;
  logic [W-1:0] w_big, w_spec_res;
  logic [W-2:0] w_sml_mag;
  logic [3:0] w_spec_st;
  logic [EXP_W-1:0] w_diff, w_exp_r;
  logic [SW-1:0] w_aln, w_big_sig;
  logic [NW-1:0] w_rsh;
  logic w_up, w_inx, w_rc, w_ovf_r;
  logic [MAN_W+1:0] w_man_r;
  logic [MAN_W-1:0] w_man;
  always_comb begin
    w_a_zero   = r_a[W-2:MAN_W] == '0;
    w_b_zero   = r_b[W-2:MAN_W] == '0;
    w_a_inf    = r_a[W-2:MAN_W] == EMAX;
    w_b_inf    = r_b[W-2:MAN_W] == EMAX;
    w_spec     = w_a_zero | w_b_zero | w_a_inf | w_b_inf;
    w_eff_sub  = r_a[W-1] ^ r_b[W-1];
    w_swap     = r_b[W-2:0] > r_a[W-2:0];
    w_big      = w_swap ? r_b : r_a;
    w_sml_mag  = w_swap ? r_a[W-2:0] : r_b[W-2:0];
    w_diff     = w_big[W-2:MAN_W] - w_sml_mag[W-2:MAN_W];
    w_big_sig  = {1'b1, w_big[MAN_W-1:0], 3'b000};
    // infinities dominate zeros; a zero operand passes the other one through untouched
    w_spec_res = (w_a_inf & w_b_inf & w_eff_sub) ? {1'b0, EMAX, {MAN_W{1'b0}}} :
                 w_a_inf ? {r_a[W-1], EMAX, {MAN_W{1'b0}}} :
                 w_b_inf ? {r_b[W-1], EMAX, {MAN_W{1'b0}}} :
                 (w_a_zero & w_b_zero) ? '0 :
                 w_a_zero ? r_b : r_a;
    w_spec_st  = (w_a_inf & w_b_inf & w_eff_sub) ? K_OVF : K_EXACT;
    w_inx      = |r_sum[2:0];
`ifdef FPU_ROUND_NEAREST_EN
    w_up       = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
`else
    w_up       = 1'b0;
`endif
    w_man_r    = {1'b0, r_sum[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, w_up};
    w_rc       = w_man_r[MAN_W+1];
    w_man      = w_rc ? w_man_r[MAN_W:1] : w_man_r[MAN_W-1:0];
    w_exp_r    = r_exp + {{(EXP_W-1){1'b0}}, w_rc};
    w_ovf_r    = r_ovf | (w_rc & (w_exp_r == EMAX));
  end
  fpu_align_shift #(.WIDTH(SW), .SHW(EXP_W)) u_aln (
    .i_data({1'b1, w_sml_mag[MAN_W-1:0], 3'b000}),
    .i_amt (w_diff),
    .o_data(w_aln)
  );
  fpu_align_shift #(.WIDTH(NW), .SHW(1)) u_rsh (
    .i_data(r_sum),
    .i_amt (1'b1),
    .o_data(w_rsh)
  );
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_st       <= '0;
      r_sign     <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_exp      <= '0;
      r_sml      <= '0;
      r_sum      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_a     <= op_A_in;
          r_b     <= {op_B_in[W-1] ^ op_sub, op_B_in[W-2:0]};
          r_ovf   <= 1'b0;
          r_unf   <= 1'b0;
          busy    <= 1'b1;
          r_state <= S_ALIGN;
        end
        S_ALIGN: begin
          r_sign  <= w_big[W-1];
          r_exp   <= w_big[W-2:MAN_W];
          r_sml   <= w_aln;
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_sum   <= w_eff_sub ? {1'b0, w_big_sig} - {1'b0, r_sml} : {1'b0, w_big_sig} + {1'b0, r_sml};
          r_state <= S_NORM;
        end
        // special operands spend one idle cycle here so every operation keeps the same minimum latency
        S_NORM: if (w_spec) begin
          r_state <= S_ROUND;
        end else if (r_sum[NW-1]) begin
          r_sum   <= w_rsh;
          r_exp   <= r_exp + E_ONE;
          r_ovf   <= (r_exp + E_ONE) == EMAX;
          r_state <= S_ROUND;
        end else if (!r_sum[NW-2] && |r_sum) begin
          if (r_exp <= E_ONE) begin
            r_unf   <= 1'b1;
            r_state <= S_ROUND;
          end else begin
            r_sum   <= r_sum << 1;
            r_exp   <= r_exp - E_ONE;
            r_state <= r_sum[NW-3] ? S_ROUND : S_NORM;
          end
        end else begin
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_res   <= w_spec ? w_spec_res :
                     w_ovf_r ? {r_sign, EMAX, {MAN_W{1'b0}}} :
                     r_unf ? {r_sign, {(EXP_W+MAN_W){1'b0}}} :
                     ~|r_sum ? '0 : {r_sign, w_exp_r, w_man};
          r_st    <= w_spec ? w_spec_st :
                     w_ovf_r ? K_OVF :
                     r_unf ? K_UNF :
                     (~|r_sum | ~w_inx) ? K_EXACT : K_INX;
          r_state <= S_DONE;
        end
        S_DONE: begin
          data_out   <= r_res;
          status_out <= r_st;
          done       <= 1'b1;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
